// File: rtl/mem_controller_pkg.sv
// Shared types and constants for the memory controller and its channels.
package mem_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } chanState_t;

    localparam int CNT_W      = 8;
    localparam int WORD_SHIFT = 2;

    // MAR holds a word index; the data memory expects a byte address.
    function automatic logic [31:0] wordToByte(input logic [31:0] word);
        return word << WORD_SHIFT;
    endfunction

endpackage

// File: rtl/mem_channel.sv
// One request/acknowledge channel: latches an address, waits for ack or timeout,
// captures read data and flags a one-cycle load in DONE.
module mem_channel
    import mem_controller_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              start,
    input  logic              startRead,
    input  logic [31:0]       startAddr,
    input  logic              ack,
    input  logic [DATA_W-1:0] rdataIn,
    output logic [31:0]       addr,
    output logic              req,
    output logic [DATA_W-1:0] rdata,
    output logic              load,
    output logic              busy,
    output logic              timeoutPulse
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT - 1);

    chanState_t       state;
    chanState_t       nextState;
    logic [CNT_W-1:0] reqCount;
    logic             readFlag;
    logic             lastCycle;

    assign lastCycle = (reqCount == LAST_COUNT);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start) nextState = REQ;
            REQ: begin
                if (ack) begin
                    nextState = DONE;
                end else if (lastCycle) begin
                    nextState = IDLE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Ack takes priority over a timeout landing on the same edge.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            addr         <= '0;
            rdata        <= '0;
            reqCount     <= '0;
            readFlag     <= 1'b0;
            timeoutPulse <= 1'b0;
        end else begin
            timeoutPulse <= 1'b0;
            if (state == IDLE && start) begin
                addr     <= startAddr;
                readFlag <= startRead;
                reqCount <= '0;
            end
            if (state == REQ) begin
                if (ack) begin
                    if (readFlag) begin
                        rdata <= rdataIn;
                    end
                end else if (lastCycle) begin
                    timeoutPulse <= 1'b1;
                end else begin
                    reqCount <= reqCount + 1'b1;
                end
            end
        end
    end

    always_comb begin
        req  = (state == REQ);
        load = (state == DONE) && readFlag;
        busy = (state != IDLE);
    end

endmodule

// File: rtl/mem_controller.sv
// Memory controller: independent data (MAR/MDR) and instruction-fetch (PC/MBR)
// channels sharing only the status outputs.
module mem_controller
    import mem_controller_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        rd,
    input  logic        wr,
    input  logic        fetch,
    input  logic [31:0] marIn,
    input  logic [31:0] mdrIn,
    input  logic [31:0] pcIn,
    output logic [31:0] mdrOut,
    output logic        mdrLoad,
    output logic [7:0]  mbrOut,
    output logic        mbrLoad,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic        memRead,
    output logic        memWrite,
    input  logic [31:0] memRdata,
    input  logic        memAck,
    output logic [31:0] ifAddr,
    output logic        ifReq,
    input  logic [7:0]  ifData,
    input  logic        ifAck,
    output logic        busy,
    output logic        timeout,
    output logic        protocolError
);

    logic dataBusy;
    logic fetchBusy;
    logic dataStart;
    logic fetchStart;
    logic dataReq;
    logic dataTimeout;
    logic fetchTimeout;
    logic dataIsWrite;
    logic cmdError;

    // rd and wr together, or any command to a channel already in flight, is rejected.
    assign dataStart  = !dataBusy && (rd ^ wr);
    assign fetchStart = !fetchBusy && fetch;
    assign cmdError   = (dataBusy ? (rd || wr) : (rd && wr)) || (fetchBusy && fetch);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            memWdata      <= '0;
            dataIsWrite   <= 1'b0;
            protocolError <= 1'b0;
        end else begin
            protocolError <= cmdError;
            if (dataStart) begin
                dataIsWrite <= wr;
                if (wr) begin
                    memWdata <= mdrIn;
                end
            end
        end
    end

    assign memRead  = dataReq && !dataIsWrite;
    assign memWrite = dataReq && dataIsWrite;
    assign busy     = dataBusy || fetchBusy;
    assign timeout  = dataTimeout || fetchTimeout;

    mem_channel #(
        .DATA_W  (32),
        .TIMEOUT (TIMEOUT)
    ) dataChannel (
        .clock        (clock),
        .resetN       (resetN),
        .start        (dataStart),
        .startRead    (rd),
        .startAddr    (wordToByte(marIn)),
        .ack          (memAck),
        .rdataIn      (memRdata),
        .addr         (memAddr),
        .req          (dataReq),
        .rdata        (mdrOut),
        .load         (mdrLoad),
        .busy         (dataBusy),
        .timeoutPulse (dataTimeout)
    );

    mem_channel #(
        .DATA_W  (8),
        .TIMEOUT (TIMEOUT)
    ) fetchChannel (
        .clock        (clock),
        .resetN       (resetN),
        .start        (fetchStart),
        .startRead    (1'b1),
        .startAddr    (pcIn),
        .ack          (ifAck),
        .rdataIn      (ifData),
        .addr         (ifAddr),
        .req          (ifReq),
        .rdata        (mbrOut),
        .load         (mbrLoad),
        .busy         (fetchBusy),
        .timeoutPulse (fetchTimeout)
    );

endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: directed vector table, multi-cycle sequences and
// randomized traffic against a transaction-level reference model.
module tb_mem_controller;

    localparam int TIMEOUT_MAIN = 255;

    logic        clock;
    logic        resetN;
    logic        rd, wr, fetch, memAck, ifAck, toAck;
    logic [31:0] marIn, mdrIn, pcIn, memRdata;
    logic [7:0]  ifData;

    logic [31:0] mdrOut, memAddr, memWdata, ifAddr;
    logic [7:0]  mbrOut;
    logic        mdrLoad, mbrLoad, memRead, memWrite, ifReq, busy, timeout, protocolError;

    logic [31:0] tMdrOut, tMemAddr, tMemWdata, tIfAddr;
    logic [7:0]  tMbrOut;
    logic        tMdrLoad, tMbrLoad, tMemRead, tMemWrite, tIfReq, tBusy, tTimeout, tProtocolError;

    logic [7:0]  flags;
    assign flags = {memRead, memWrite, ifReq, mdrLoad, mbrLoad, busy, timeout, protocolError};

    int vectors = 0;
    int errors  = 0;

    // Reference model: outstanding transaction per channel plus the latched values.
    bit          modelOn = 0;
    bit          mOpenD, mFinD, mIsWr, mOpenF, mFinF, mErr, mTo;
    int          mWaitD, mWaitF;
    logic [31:0] mMemAddr, mMemWdata, mMdrOut, mIfAddr;
    logic [7:0]  mMbrOut;

    typedef struct {
        logic [4:0]  cmd;
        logic [31:0] mar;
        logic [31:0] mdr;
        logic [31:0] pc;
        logic [31:0] mrd;
        logic [7:0]  ifd;
        logic [7:0]  expFlags;
        logic [31:0] expMemAddr;
        logic [31:0] expIfAddr;
        logic [31:0] expMdrOut;
        logic [7:0]  expMbrOut;
    } vector_t;

    vector_t vecs[19];

    mem_controller dut (
        .clock(clock), .resetN(resetN), .rd(rd), .wr(wr), .fetch(fetch),
        .marIn(marIn), .mdrIn(mdrIn), .pcIn(pcIn),
        .mdrOut(mdrOut), .mdrLoad(mdrLoad), .mbrOut(mbrOut), .mbrLoad(mbrLoad),
        .memAddr(memAddr), .memWdata(memWdata), .memRead(memRead), .memWrite(memWrite),
        .memRdata(memRdata), .memAck(memAck),
        .ifAddr(ifAddr), .ifReq(ifReq), .ifData(ifData), .ifAck(ifAck),
        .busy(busy), .timeout(timeout), .protocolError(protocolError)
    );

    mem_controller #(.TIMEOUT(4)) dutTo (
        .clock(clock), .resetN(resetN), .rd(rd), .wr(wr), .fetch(fetch),
        .marIn(marIn), .mdrIn(mdrIn), .pcIn(pcIn),
        .mdrOut(tMdrOut), .mdrLoad(tMdrLoad), .mbrOut(tMbrOut), .mbrLoad(tMbrLoad),
        .memAddr(tMemAddr), .memWdata(tMemWdata), .memRead(tMemRead), .memWrite(tMemWrite),
        .memRdata(memRdata), .memAck(toAck),
        .ifAddr(tIfAddr), .ifReq(tIfReq), .ifData(ifData), .ifAck(ifAck),
        .busy(tBusy), .timeout(tTimeout), .protocolError(tProtocolError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        {rd, wr, fetch, memAck, ifAck, toAck} = '0;
        marIn = '0; mdrIn = '0; pcIn = '0; memRdata = '0; ifData = '0;
    endtask

    task automatic applyStimulus(input vector_t v);
        {rd, wr, fetch, memAck, ifAck} = v.cmd;
        marIn = v.mar; mdrIn = v.mdr; pcIn = v.pc; memRdata = v.mrd; ifData = v.ifd;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "MdrOut"},   mdrOut,   32'h0);
        checkOutput({tag, "MbrOut"},   {24'h0, mbrOut}, 32'h0);
        checkOutput({tag, "MemAddr"},  memAddr,  32'h0);
        checkOutput({tag, "MemWdata"}, memWdata, 32'h0);
        checkOutput({tag, "IfAddr"},   ifAddr,   32'h0);
        checkOutput({tag, "Flags"},    {24'h0, flags}, 32'h0);
    endtask

    task automatic modelStep();
        bit dBusy;
        bit fBusy;
        dBusy = mOpenD || mFinD;
        fBusy = mOpenF || mFinF;
        mErr = 0;
        mTo  = 0;
        if (mFinD) begin
            mFinD = 0;
        end else if (mOpenD) begin
            if (memAck) begin
                mOpenD = 0; mFinD = 1;
                if (!mIsWr) mMdrOut = memRdata;
            end else if (mWaitD + 1 == TIMEOUT_MAIN) begin
                mOpenD = 0; mTo = 1;
            end else begin
                mWaitD++;
            end
        end
        if (dBusy) begin
            if (rd || wr) mErr = 1;
        end else if (rd && wr) begin
            mErr = 1;
        end else if (rd || wr) begin
            mOpenD = 1; mWaitD = 0; mIsWr = wr;
            mMemAddr = marIn << 2;
            if (wr) mMemWdata = mdrIn;
        end
        if (mFinF) begin
            mFinF = 0;
        end else if (mOpenF) begin
            if (ifAck) begin
                mOpenF = 0; mFinF = 1; mMbrOut = ifData;
            end else if (mWaitF + 1 == TIMEOUT_MAIN) begin
                mOpenF = 0; mTo = 1;
            end else begin
                mWaitF++;
            end
        end
        if (fBusy) begin
            if (fetch) mErr = 1;
        end else if (fetch) begin
            mOpenF = 1; mWaitF = 0; mIfAddr = pcIn;
        end
    endtask

    task automatic stepCycle();
        @(posedge clock);
        if (modelOn) modelStep();
        @(negedge clock);
    endtask

    task automatic doReset();
        resetN = 1'b0;
        clearInputs();
        #1;
        checkAllZero("rst");
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1;
        {mOpenD, mFinD, mIsWr, mOpenF, mFinF, mErr, mTo} = '0;
        mWaitD = 0; mWaitF = 0;
        mMemAddr = '0; mMemWdata = '0; mMdrOut = '0; mIfAddr = '0; mMbrOut = '0;
    endtask

    // Watchdog so the run always ends even if the bench itself misbehaves.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // cmd = {rd, wr, fetch, memAck, ifAck}; expFlags = {memRead, memWrite, ifReq, mdrLoad, mbrLoad, busy, timeout, protocolError}
        vecs[0]  = '{5'b10000, 32'h10, 32'h0,  32'h0,   32'h0,        8'h00, 8'b10000100, 32'h40,  32'h0,   32'h0,        8'h00};
        vecs[1]  = '{5'b00010, 32'h10, 32'h0,  32'h0,   32'hDEADBEEF, 8'h00, 8'b00010100, 32'h40,  32'h0,   32'hDEADBEEF, 8'h00};
        vecs[2]  = '{5'b00000, 32'h0,  32'h0,  32'h0,   32'h0,        8'h00, 8'b00000000, 32'h40,  32'h0,   32'hDEADBEEF, 8'h00};
        vecs[3]  = '{5'b10100, 32'h20, 32'h0,  32'h7,   32'h0,        8'h00, 8'b10100100, 32'h80,  32'h7,   32'hDEADBEEF, 8'h00};
        vecs[4]  = '{5'b00011, 32'h0,  32'h0,  32'h0,   32'h11223344, 8'hA5, 8'b00011100, 32'h80,  32'h7,   32'h11223344, 8'hA5};
        vecs[5]  = '{5'b00000, 32'h0,  32'h0,  32'h0,   32'h0,        8'h00, 8'b00000000, 32'h80,  32'h7,   32'h11223344, 8'hA5};
        vecs[6]  = '{5'b11000, 32'h30, 32'h9,  32'h0,   32'h0,        8'h00, 8'b00000001, 32'h80,  32'h7,   32'h11223344, 8'hA5};
        vecs[7]  = '{5'b10000, 32'h3,  32'h0,  32'h0,   32'h0,        8'h00, 8'b10000100, 32'hC,   32'h7,   32'h11223344, 8'hA5};
        vecs[8]  = '{5'b10000, 32'h5,  32'h0,  32'h0,   32'h0,        8'h00, 8'b10000101, 32'hC,   32'h7,   32'h11223344, 8'hA5};
        vecs[9]  = '{5'b00010, 32'h0,  32'h0,  32'h0,   32'hCAFEF00D, 8'h00, 8'b00010100, 32'hC,   32'h7,   32'hCAFEF00D, 8'hA5};
        vecs[10] = '{5'b00000, 32'h0,  32'h0,  32'h0,   32'h0,        8'h00, 8'b00000000, 32'hC,   32'h7,   32'hCAFEF00D, 8'hA5};
        vecs[11] = '{5'b00011, 32'h0,  32'h0,  32'h0,   32'h99,       8'h11, 8'b00000000, 32'hC,   32'h7,   32'hCAFEF00D, 8'hA5};
        vecs[12] = '{5'b00100, 32'h0,  32'h0,  32'h100, 32'h0,        8'h00, 8'b00100100, 32'hC,   32'h100, 32'hCAFEF00D, 8'hA5};
        vecs[13] = '{5'b00100, 32'h0,  32'h0,  32'h200, 32'h0,        8'h00, 8'b00100101, 32'hC,   32'h100, 32'hCAFEF00D, 8'hA5};
        vecs[14] = '{5'b00001, 32'h0,  32'h0,  32'h0,   32'h0,        8'h3C, 8'b00001100, 32'hC,   32'h100, 32'hCAFEF00D, 8'h3C};
        vecs[15] = '{5'b00000, 32'h0,  32'h0,  32'h0,   32'h0,        8'h00, 8'b00000000, 32'hC,   32'h100, 32'hCAFEF00D, 8'h3C};
        vecs[16] = '{5'b01000, 32'h1,  32'hAB, 32'h0,   32'h0,        8'h00, 8'b01000100, 32'h4,   32'h100, 32'hCAFEF00D, 8'h3C};
        vecs[17] = '{5'b00010, 32'h0,  32'h0,  32'h0,   32'h77,       8'h00, 8'b00000100, 32'h4,   32'h100, 32'hCAFEF00D, 8'h3C};
        vecs[18] = '{5'b10000, 32'h9,  32'h0,  32'h0,   32'h0,        8'h00, 8'b00000001, 32'h4,   32'h100, 32'hCAFEF00D, 8'h3C};

        resetN = 1'b1;
        clearInputs();
        #2;

        doReset();
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i]);
            stepCycle();
            checkOutput("tblFlags",   {24'h0, flags},  {24'h0, vecs[i].expFlags});
            checkOutput("tblMemAddr", memAddr,         vecs[i].expMemAddr);
            checkOutput("tblIfAddr",  ifAddr,          vecs[i].expIfAddr);
            checkOutput("tblMdrOut",  mdrOut,          vecs[i].expMdrOut);
            checkOutput("tblMbrOut",  {24'h0, mbrOut}, {24'h0, vecs[i].expMbrOut});
        end
        clearInputs();

        // Write held for six REQ cycles while the source registers change underneath.
        doReset();
        wr = 1'b1; mdrIn = 32'h12345678; marIn = 32'h44;
        for (int i = 0; i < 6; i++) begin
            stepCycle();
            if (i == 0) begin
                wr = 1'b0; mdrIn = 32'hFFFFFFFF; marIn = 32'h0;
            end
            checkBit("wrHoldStrobe", memWrite, 1'b1);
            checkBit("wrHoldNoRead", memRead, 1'b0);
            checkOutput("wrHoldData", memWdata, 32'h12345678);
            checkOutput("wrHoldAddr", memAddr, 32'h110);
            checkBit("wrHoldLoad", mdrLoad, 1'b0);
        end
        memAck = 1'b1; memRdata = 32'h55AA55AA;
        stepCycle();
        memAck = 1'b0;
        checkBit("wrDoneStrobe", memWrite, 1'b0);
        checkBit("wrDoneLoad", mdrLoad, 1'b0);
        checkBit("wrDoneBusy", busy, 1'b1);
        stepCycle();
        checkBit("wrIdleBusy", busy, 1'b0);
        checkBit("wrIdleLoad", mdrLoad, 1'b0);
        checkOutput("wrMdrUntouched", mdrOut, 32'h0);

        // TIMEOUT=4 instance: read with no acknowledge ever arriving.
        doReset();
        rd = 1'b1; marIn = 32'h8;
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            if (i == 0) rd = 1'b0;
            checkBit("toReqRead", tMemRead, 1'b1);
            checkBit("toReqFlag", tTimeout, 1'b0);
        end
        stepCycle();
        checkBit("toDropRead", tMemRead, 1'b0);
        checkBit("toPulse", tTimeout, 1'b1);
        checkBit("toNoLoad", tMdrLoad, 1'b0);
        checkBit("toIdle", tBusy, 1'b0);
        stepCycle();
        checkBit("toPulseEnd", tTimeout, 1'b0);
        checkBit("toNoLoadLate", tMdrLoad, 1'b0);

        // Reset in the middle of a write and a fetch.
        doReset();
        wr = 1'b1; fetch = 1'b1; mdrIn = 32'h55; marIn = 32'h3; pcIn = 32'h9;
        stepCycle();
        wr = 1'b0; fetch = 1'b0;
        checkBit("midWrite", memWrite, 1'b1);
        checkBit("midIfReq", ifReq, 1'b1);
        #2;
        resetN = 1'b0;
        #1;
        checkAllZero("midRst");
        memAck = 1'b1; ifAck = 1'b1; memRdata = 32'h1234; ifData = 8'h77;
        @(negedge clock);
        resetN = 1'b1;
        for (int i = 0; i < 2; i++) begin
            stepCycle();
            checkBit("postRstMdrLoad", mdrLoad, 1'b0);
            checkBit("postRstMbrLoad", mbrLoad, 1'b0);
            checkOutput("postRstMdrOut", mdrOut, 32'h0);
            checkBit("postRstBusy", busy, 1'b0);
        end

        // Randomized traffic on both channels against the reference model.
        doReset();
        modelOn = 1;
        for (int i = 0; i < 400; i++) begin
            rd       = ($urandom_range(0, 99) < 20);
            wr       = ($urandom_range(0, 99) < 20);
            fetch    = ($urandom_range(0, 99) < 25);
            memAck   = ($urandom_range(0, 99) < 35);
            ifAck    = ($urandom_range(0, 99) < 35);
            marIn    = $urandom;
            mdrIn    = $urandom;
            pcIn     = $urandom;
            memRdata = $urandom;
            ifData   = 8'($urandom);
            stepCycle();
            checkOutput("rndFlags", {24'h0, flags},
                        {24'h0, mOpenD && !mIsWr, mOpenD && mIsWr, mOpenF, mFinD && !mIsWr, mFinF,
                         mOpenD || mFinD || mOpenF || mFinF, mTo, mErr});
            checkOutput("rndMemAddr",  memAddr,  mMemAddr);
            checkOutput("rndMemWdata", memWdata, mMemWdata);
            checkOutput("rndIfAddr",   ifAddr,   mIfAddr);
            checkOutput("rndMdrOut",   mdrOut,   mMdrOut);
            checkOutput("rndMbrOut",   {24'h0, mbrOut}, {24'h0, mMbrOut});
        end
        modelOn = 0;
        clearInputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mem_controller.md
MEM_CONTROLLER -- requirements
Module: mem_controller

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum wait cycles for an acknowledge; legal range 1..255.
REQ-002 Port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-003 Port resetN, input, 1: reset, asynchronous, active-low.
REQ-004 Ports rd, wr, fetch, input, 1 each: memory commands from the microinstruction, sampled every rising edge.
REQ-005 Ports marIn, mdrIn, pcIn, input, 32 each: always-on outputs of the MAR, MDR and PC registers.
REQ-006 Ports mdrOut (output, 32) and mdrLoad (output, 1): data and inEnable for the MDR register.
REQ-007 Ports mbrOut (output, 8) and mbrLoad (output, 1): byte and inEnable for the MBR register.
REQ-008 Ports memAddr (output, 32), memWdata (output, 32), memRead (output, 1), memWrite (output, 1), memRdata (input, 32), memAck (input, 1): data-memory port.
REQ-009 Ports ifAddr (output, 32), ifReq (output, 1), ifData (input, 8), ifAck (input, 1): instruction-fetch port.
REQ-010 Ports busy (output, 1), timeout (output, 1), protocolError (output, 1): status.

Function
REQ-011 The data channel and the fetch channel SHALL each run an independent FSM with states IDLE, REQ, DONE.
REQ-012 In IDLE, rd=1 with wr=0 at an edge SHALL latch memAddr={marIn[29:0],2'b00}, set memRead=1 and enter REQ.
REQ-013 In IDLE, wr=1 with rd=0 at an edge SHALL latch the address as in REQ-012, latch memWdata=mdrIn, set memWrite=1 and enter REQ.
REQ-014 In IDLE, rd=1 and wr=1 together SHALL start no request and SHALL pulse protocolError for one cycle.
REQ-015 In data REQ, memRead/memWrite, memAddr and memWdata SHALL stay stable until memAck is sampled 1.
REQ-016 On memAck=1 during a read, memRdata SHALL be captured into mdrOut; mdrLoad SHALL be 1 for exactly the next cycle (DONE); the FSM SHALL then return to IDLE.
REQ-017 On memAck=1 during a write, the FSM SHALL pass through DONE for one cycle with mdrLoad=0, then return to IDLE.
REQ-018 Minimum latency SHALL be 2 edges from command sample to mdrLoad high.
REQ-019 In fetch IDLE, fetch=1 SHALL latch ifAddr=pcIn (byte address, no shift), set ifReq=1 and enter REQ.
REQ-020 On ifAck=1, ifData SHALL be captured into mbrOut and mbrLoad SHALL pulse for one cycle, mirroring REQ-016.
REQ-021 A command arriving while its channel is not IDLE SHALL be dropped and SHALL pulse protocolError; the transfer in progress SHALL be unaffected.
REQ-022 Each channel SHALL count REQ cycles in an 8-bit counter; when the count reaches TIMEOUT without an acknowledge, the channel SHALL deassert its request, return to IDLE without a load pulse, and pulse timeout for one cycle.
REQ-023 A data and a fetch command in the same cycle SHALL both start; the channels SHALL never block each other.
REQ-024 busy SHALL be 1 whenever either channel is not IDLE.
REQ-025 An acknowledge sampled in IDLE or DONE SHALL be ignored.

Reset
REQ-026 While resetN=0, both FSMs SHALL be IDLE, the counters 0, and every output 0: mdrOut, mbrOut, memAddr, memWdata, ifAddr, all strobes and all status flags.
REQ-027 Reset asserted mid-transfer SHALL abort it immediately, with no load pulse after release.

Structure
REQ-028 A shared package SHALL hold the state enumeration (IDLE/REQ/DONE), the counter width (8) and the word-to-byte shift constant (2).
REQ-029 One sub-module, mem_channel, parameterised by data width (32 or 8), SHALL implement the FSM and timeout logic; it SHALL be instantiated twice.

Verification
REQ-030 marIn=0x10, rd pulse, memAck on the first REQ cycle, memRdata=0xDEADBEEF -> memAddr=0x40; mdrOut=0xDEADBEEF; mdrLoad high exactly one cycle, 2 edges after the command.
REQ-031 wr with mdrIn=0x12345678, memAck delayed 5 cycles -> memWrite and memWdata stable for 6 cycles; no mdrLoad pulse.
REQ-032 pcIn=0x7, fetch together with rd, ifData=0xA5 -> ifAddr=0x7; mbrOut=0xA5 and mdrLoad both pulse; busy high throughout.
REQ-033 TIMEOUT=4, rd with no memAck -> memRead drops after 4 REQ cycles; timeout pulses once; no mdrLoad.
REQ-034 rd and wr together, and a second rd during REQ -> protocolError pulses each time; the original transfer completes normally.
REQ-035 resetN driven low during data REQ -> all outputs 0 immediately; no mdrLoad after release.
